// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity-mode codes and
// the bit-period helper used by both the transmit and future receive paths.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // Integer-truncated clock cycles per line bit; 0 flags an unusable rate.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        if (baud_rate == 0) begin
            return 0;
        end
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level = wr_q - rd_q;
    assign rdata = mem[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push && !full) begin
            wr_d = wr_q + PW'(1);
        end
        if (pop && !empty) begin
            rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with valid/ready input. UART_TX_FIFO_EN selects
// a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
`timescale 1ns/1ps
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 200000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_BITS-1:0]          TX_DATA,
    input  logic                          TX_VALID,
    output logic                          TX_READY,
    output logic                          SO,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W        = 4;
    localparam bit          HAS_PARITY   = (PARITY_MODE != PARITY_NONE);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > PARITY_ODD ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_tx_frame: illegal parameter combination");
    end

    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] head_data;

    assign TX_READY = !fifo_full;
    assign push     = TX_VALID && TX_READY;

`ifdef UART_TX_FIFO_EN
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_frame: FIFO_DEPTH must be a power of two, at least 2");
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .wdata (TX_DATA),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FIFO_LEVEL)
    );
`else
    logic                 hold_valid_q, hold_valid_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;

    // Push and pop are mutually exclusive: push needs it empty, pop needs it full.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (pop) begin
            hold_valid_d = 1'b0;
        end
        if (push) begin
            hold_valid_d = 1'b1;
            hold_data_d  = TX_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign fifo_full  = hold_valid_q;
    assign fifo_empty = !hold_valid_q;
    assign head_data  = hold_data_q;
    assign FIFO_LEVEL = LVL_W'(hold_valid_q);
`endif

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 so_q, so_d;
    logic                 busy_q, busy_d;
    logic                 bit_done;

    assign bit_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_done ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        so_d    = 1'b1;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                pop   = !fifo_empty;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = HAS_PARITY ? PARITY : STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        if (fifo_empty) begin
                            state_d = IDLE;
                        end else begin
                            pop = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading a word always starts a fresh frame, from IDLE or back to back.
        if (pop) begin
            state_d = START;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = head_data;
            par_d   = (^head_data) ^ (PARITY_MODE == PARITY_ODD);
        end

        case (state_d)
            START:   so_d = 1'b0;
            DATA:    so_d = shift_d[0];
            PARITY:  so_d = par_d;
            default: so_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
        end
    end

    assign SO   = so_q;
    assign BUSY = busy_q;

endmodule
